// File: rtl/link_pkg.sv
// Shared definitions for the board-to-board serial link (transmitter and receiver).
// Word layout: {ready, hit, cords[7:0]}, sent LSB first.
package link_pkg;

    localparam int LINK_WORD_W           = 10;
    localparam int LINK_FRAME_BITS_PAR   = 13;
    localparam int LINK_FRAME_BITS_NOPAR = 12;
    localparam int LINK_BIT_READY        = 9;
    localparam int LINK_BIT_HIT          = 8;
    localparam int LINK_CORDS_LSB        = 0;
    localparam int LINK_CORDS_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } link_state_e;

    typedef logic [LINK_WORD_W-1:0] link_word_t;

    function automatic link_word_t link_pack(input logic ready, input logic hit,
                                             input logic [LINK_CORDS_W-1:0] cords);
        link_word_t w;
        w = '0;
        w[LINK_BIT_READY] = ready;
        w[LINK_BIT_HIT]   = hit;
        w[LINK_CORDS_LSB +: LINK_CORDS_W] = cords;
        return w;
    endfunction

endpackage

// File: rtl/link_tx_if.sv
// Game-FSM side of the link transmitter: word inputs, enable, serial line and status.
interface link_tx_if;
    import link_pkg::*;

    logic                    ready_in;
    logic                    hit_in;
    logic [LINK_CORDS_W-1:0] cords_in;
    logic                    tx_en;
    logic                    tx;
    logic                    busy;
    logic [7:0]              frame_cnt;

    modport slave (
        input  ready_in, hit_in, cords_in, tx_en,
        output tx, busy, frame_cnt
    );

    modport master (
        output ready_in, hit_in, cords_in, tx_en,
        input  tx, busy, frame_cnt
    );

endinterface

// File: rtl/link_baud_gen.sv
// Bit-period timer: one-cycle tick every CLK_DIV cycles, restarted by a synchronous clear.
module link_baud_gen #(
    parameter int CLK_DIV = 650
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] TERM = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == TERM);
        cnt_d = cnt_q + 16'd1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/link_tx.sv
// Serial link transmitter: sends {ready, hit, cords} on change or periodic refresh.
// Optional even parity bit is built in when macro LINK_PARITY_EN is defined.
module link_tx
    import link_pkg::*;
#(
    parameter int CLK_DIV        = 650,
    parameter int REFRESH_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    link_tx_if.slave   bus
);

`ifdef LINK_PARITY_EN
    localparam int FRAME_BITS = LINK_FRAME_BITS_PAR;
`else
    localparam int FRAME_BITS = LINK_FRAME_BITS_NOPAR;
`endif
    localparam logic [3:0]  LAST_IDLE_TICK = 4'(FRAME_BITS - 1);
    localparam logic [3:0]  LAST_DATA_BIT  = 4'(LINK_WORD_W - 1);
    localparam logic [15:0] REFRESH_LIM    = 16'(REFRESH_FRAMES);

    link_state_e state_q, state_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  bit_q, bit_d;
    link_word_t  word_q, word_d;
    link_word_t  last_q, last_d;
    logic        last_vld_q, last_vld_d;
    logic [3:0]  idle_bits_q, idle_bits_d;
    logic [15:0] refresh_q, refresh_d;

    logic        tick;
    logic        baud_clr;
    logic        expired;
    logic        trigger;
    logic [15:0] refresh_nxt;
    logic [3:0]  bit_nxt;
    link_word_t  w_in;

    assign w_in = link_pack(bus.ready_in, bus.hit_in, bus.cords_in);

    link_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        frame_cnt_d = frame_cnt_q;
        bit_d       = bit_q;
        word_d      = word_q;
        last_d      = last_q;
        last_vld_d  = last_vld_q;
        idle_bits_d = idle_bits_q;
        refresh_d   = refresh_q;
        refresh_nxt = refresh_q;
        baud_clr    = 1'b0;
        expired     = 1'b0;
        trigger     = 1'b0;
        bit_nxt     = bit_q + 4'd1;

        case (state_q)
            IDLE: begin
                // Idle time is measured in whole frame periods of baud ticks.
                if (tick) begin
                    if (idle_bits_q == LAST_IDLE_TICK) begin
                        idle_bits_d = '0;
                        if (refresh_q != REFRESH_LIM) begin
                            refresh_nxt = refresh_q + 16'd1;
                        end
                    end else begin
                        idle_bits_d = idle_bits_q + 4'd1;
                    end
                end
                refresh_d = refresh_nxt;
                expired   = (REFRESH_FRAMES != 0) && (refresh_nxt == REFRESH_LIM);
                trigger   = bus.tx_en && (!last_vld_q || (w_in != last_q) || expired);
                if (trigger) begin
                    state_d     = START;
                    tx_d        = 1'b0;
                    word_d      = w_in;
                    last_d      = w_in;
                    last_vld_d  = 1'b1;
                    baud_clr    = 1'b1;
                    idle_bits_d = '0;
                    refresh_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = word_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_DATA_BIT) begin
`ifdef LINK_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^word_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = word_q[bit_nxt];
                    end
                end
            end
`ifdef LINK_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d     = IDLE;
                    tx_d        = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            bit_q       <= '0;
            word_q      <= '0;
            last_q      <= '0;
            last_vld_q  <= 1'b0;
            idle_bits_q <= '0;
            refresh_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            bit_q       <= bit_d;
            word_q      <= word_d;
            last_q      <= last_d;
            last_vld_q  <= last_vld_d;
            idle_bits_q <= idle_bits_d;
            refresh_q   <= refresh_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_link_tx.sv
// Directed bench for link_tx (CLK_DIV=4, REFRESH_FRAMES=2); frame length follows LINK_PARITY_EN.
module tb_link_tx;
    import link_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int REFRESH = 2;
`ifdef LINK_PARITY_EN
    localparam int FB  = 13;
    localparam bit PAR = 1'b1;
`else
    localparam int FB  = 12;
    localparam bit PAR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;

    link_tx_if bus();

    link_tx #(.CLK_DIV(CLK_DIV), .REFRESH_FRAMES(REFRESH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial bit at frame position idx: start, W[0..9], [parity], stop.
    function automatic logic exp_bit(input logic [9:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 10) return w[idx-1];
        if (PAR && idx == 11) return ^w;
        return 1'b1;
    endfunction

    // Called at the negedge where the start bit is first visible; ends on the idle cycle after stop.
    task automatic check_frame(input logic [9:0] w, input string tag, input int chg_at,
                               input logic [7:0] chg_cords, input int en_off_at);
        for (int c = 0; c < FB*CLK_DIV; c++) begin
            if (c > 0) @(negedge clk);
            if (c == chg_at) bus.cords_in = chg_cords;
            if (c == en_off_at) bus.tx_en = 1'b0;
            check({tag, "_tx"}, 32'(bus.tx), 32'(exp_bit(w, c / CLK_DIV)));
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        exp_cnt = (exp_cnt + 1) % 256;
        check({tag, "_idle_tx"}, 32'(bus.tx), 32'd1);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(exp_cnt));
    endtask

    // Counts idle negedges after the current one until tx goes low (bounded).
    task automatic wait_start(input string tag, input int exp_idle);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.tx !== 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_idle_cycles"}, 32'(n), 32'(exp_idle));
    endtask

    initial begin
        int ones;
        bus.ready_in = 1'b0;
        bus.hit_in   = 1'b0;
        bus.cords_in = 8'h00;
        bus.tx_en    = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst_n = 1'b1;

        // Disabled link stays idle
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b1 && bus.busy === 1'b0) ones++;
        end
        check("disabled_idle", 32'(ones), 32'd20);

        // First frame after reset, W=0
        bus.tx_en = 1'b1;
        wait_start("f000", 0);
        check_frame(10'h000, "f000", -1, 8'h00, -1);

        // W = {1,1,5A}
        bus.ready_in = 1'b1;
        bus.hit_in   = 1'b1;
        bus.cords_in = 8'h5A;
        wait_start("f35a", 0);
        check_frame(10'h35A, "f35a", -1, 8'h00, -1);

        // Mid-frame change: old word goes out, new one follows after one idle cycle
        bus.cords_in = 8'h22;
        wait_start("fk", 0);
        check_frame(10'h322, "fk", 5*CLK_DIV + 1, 8'h11, -1);
        wait_start("fk1", 0);
        check_frame(10'h311, "fk1", -1, 8'h00, -1);

        // Refresh after two idle frame periods; tx_en drop mid-frame does not abort
        wait_start("refresh", REFRESH*FB*CLK_DIV - 1);
        check_frame(10'h311, "fref", -1, 8'h00, 8);

        // Disabled: changed word is not sent
        bus.cords_in = 8'h67;
        ones = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b1 && bus.busy === 1'b0) ones++;
        end
        check("disabled_no_frames", 32'(ones), 32'd250);
        check("disabled_frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));

        // Reset in the middle of W[4]
        bus.tx_en = 1'b1;
        wait_start("frst", 0);
        for (int c = 1; c <= 5*CLK_DIV + 1; c++) @(negedge clk);
        check("mid_w4_tx", 32'(bus.tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(bus.tx), 32'd1);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        check("held_rst_tx", 32'(bus.tx), 32'd1);
        rst_n = 1'b1;
        wait_start("post_rst", 0);
        check_frame(10'h367, "post_rst", -1, 8'h00, -1);

        // All-ones word
        bus.cords_in = 8'hFF;
        wait_start("f3ff", 0);
        check_frame(10'h3FF, "f3ff", -1, 8'h00, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
